// File: rtl/ucsbece154a_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ucsbece154a_fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StValid,
        StErr
    } fetch_state_e;

endpackage

// File: rtl/ucsbece154a_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one instruction at a time over a
// request/response memory handshake and holds it until the core retires it.
module ucsbece154a_fetch
    import ucsbece154a_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,

    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,

    output logic [31:0] Instr_o,
    output logic [31:0] PC_o,
    output logic [31:0] PCPlus4_o,
    output logic        InstrValid_o,

    input  logic        retire_i,
    input  logic        PCSrc_i,
    input  logic [31:0] PCTarget_i,

    output logic        misalign_o,
    output logic        timeout_o
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            misalign_q, misalign_d;
    logic            timeout_q, timeout_d;

    logic [31:0]     pc_plus4;
    logic [31:0]     next_pc;
    logic [CntW-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        cnt_d      = cnt_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;

        pc_plus4 = pc_q + 32'(INSTR_BYTES);
        next_pc  = PCSrc_i ? PCTarget_i : pc_plus4;
        cnt_inc  = cnt_q + 1'b1;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem_ready_i) begin
                    // Zero-wait memory answers in the accept cycle.
                    if (imem_rvalid_i) begin
                        instr_d = imem_rdata_i;
                        state_d = StValid;
                    end else begin
                        cnt_d   = '0;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // A response in the final allowed cycle still beats the timeout.
                if (imem_rvalid_i) begin
                    instr_d = imem_rdata_i;
                    state_d = StValid;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntMax) begin
                        timeout_d = 1'b1;
                        state_d   = StErr;
                    end
                end
            end
            StValid: begin
                if (retire_i) begin
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = StErr;
                    end else begin
                        pc_d    = next_pc;
                        state_d = StReq;
                    end
                end
            end
            StErr: state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    assign imem_req_o   = (state_q == StReq);
    assign imem_addr_o  = pc_q;
    assign Instr_o      = instr_q;
    assign PC_o         = pc_q;
    assign PCPlus4_o    = pc_plus4;
    assign InstrValid_o = (state_q == StValid);
    assign misalign_o   = misalign_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_ucsbece154a_fetch.sv
// Self-checking bench for ucsbece154a_fetch: directed table, hand-written corner
// sequences and a randomized program checked against a transaction-level PC model.
module tb_ucsbece154a_fetch;

    localparam int unsigned MAX_WAIT = 16;

    logic        clk;
    logic        reset_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] Instr_o;
    logic [31:0] PC_o;
    logic [31:0] PCPlus4_o;
    logic        InstrValid_o;
    logic        retire_i;
    logic        PCSrc_i;
    logic [31:0] PCTarget_i;
    logic        misalign_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    ucsbece154a_fetch #(
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .Instr_o      (Instr_o),
        .PC_o         (PC_o),
        .PCPlus4_o    (PCPlus4_o),
        .InstrValid_o (InstrValid_o),
        .retire_i     (retire_i),
        .PCSrc_i      (PCSrc_i),
        .PCTarget_i   (PCTarget_i),
        .misalign_o   (misalign_o),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int          rdy;   // cycles ready held low
        int          rsp;   // WAIT cycles until rvalid (0 = same-cycle response)
        logic [31:0] word;
        int          ret;   // cycles held in VALID before retire
        logic        src;
        logic [31:0] tgt;
        logic [31:0] addr;  // expected fetch address
    } vec_t;

    vec_t tbl[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'hBAD0_BAD0;
        retire_i      = 1'b0;
        PCSrc_i       = 1'b0;
        PCTarget_i    = '0;
        repeat (2) step();
        check1("rst_req", imem_req_o, 1'b0);
        check1("rst_valid", InstrValid_o, 1'b0);
        check32("rst_instr", Instr_o, 32'h0);
        check32("rst_pc", PC_o, 32'h0);
        check1("rst_misalign", misalign_o, 1'b0);
        check1("rst_timeout", timeout_o, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req_o !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        check1("req_seen", imem_req_o, 1'b1);
    endtask

    task automatic fetch_one(input int rdy, input int rsp, input logic [31:0] word,
                             input logic [31:0] addr);
        wait_req();
        check32("req_addr", imem_addr_o, addr);
        for (int i = 0; i < rdy; i++) begin
            imem_rvalid_i = (i == 0);  // rvalid without ready must be ignored
            step();
            imem_rvalid_i = 1'b0;
            check1("req_held", imem_req_o, 1'b1);
            check32("req_addr_stable", imem_addr_o, addr);
        end
        imem_ready_i = 1'b1;
        if (rsp == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = word;
        end
        step();
        imem_ready_i  = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom();
        if (rsp > 0) begin
            check1("wait_no_req", imem_req_o, 1'b0);
            repeat (rsp - 1) step();
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = word;
            step();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom();
        end
        check1("instr_valid", InstrValid_o, 1'b1);
        check32("instr", Instr_o, word);
        check32("pc", PC_o, addr);
        check32("pc_plus4", PCPlus4_o, addr + 32'd4);
        check1("no_timeout", timeout_o, 1'b0);
    endtask

    task automatic do_retire(input int ret, input logic src, input logic [31:0] tgt,
                             input logic [31:0] word);
        for (int i = 0; i < ret; i++) begin
            PCSrc_i    = 1'b1;
            PCTarget_i = 32'h0000_0ABC;
            step();
            check1("hold_valid", InstrValid_o, 1'b1);
            check32("hold_instr", Instr_o, word);
        end
        retire_i   = 1'b1;
        PCSrc_i    = src;
        PCTarget_i = tgt;
        step();
        retire_i   = 1'b0;
        PCSrc_i    = 1'b0;
        PCTarget_i = '0;
        check1("valid_falls", InstrValid_o, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] pc_m;
        logic [31:0] tmp;
        logic        src;

        tbl[0] = '{rdy: 0, rsp: 0,  word: 32'h0050_0113, ret: 0, src: 1'b1, tgt: 32'h0000_0040,
                   addr: 32'h0000_0000};
        tbl[1] = '{rdy: 3, rsp: 5,  word: 32'h0000_006F, ret: 1, src: 1'b1, tgt: 32'h0000_003C,
                   addr: 32'h0000_0040};
        tbl[2] = '{rdy: 0, rsp: 1,  word: 32'h0020_8093, ret: 0, src: 1'b0, tgt: 32'h0000_0000,
                   addr: 32'h0000_003C};
        tbl[3] = '{rdy: 1, rsp: MAX_WAIT, word: 32'h1234_5678, ret: 2, src: 1'b1,
                   tgt: 32'hFFFF_FFFC, addr: 32'h0000_0040};
        tbl[4] = '{rdy: 0, rsp: 2,  word: 32'hCAFE_F00D, ret: 0, src: 1'b0, tgt: 32'h0000_0000,
                   addr: 32'hFFFF_FFFC};
        tbl[5] = '{rdy: 2, rsp: 0,  word: 32'h0000_0013, ret: 0, src: 1'b0, tgt: 32'h0000_0000,
                   addr: 32'h0000_0000};
        tbl[6] = '{rdy: 0, rsp: 3,  word: 32'h00A0_0513, ret: 1, src: 1'b0, tgt: 32'h0000_0000,
                   addr: 32'h0000_0004};

        // Reset, stale rvalid in IDLE, then zero-wait sequential throughput.
        do_reset();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        check1("idle_no_valid", InstrValid_o, 1'b0);
        step();
        imem_rvalid_i = 1'b0;
        check1("idle_stale_ignored", InstrValid_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = 32'h0050_0113 ^ 32'(i << 20);
            check1("seq_req", imem_req_o, 1'b1);
            check32("seq_addr", imem_addr_o, 32'(i * 4));
            imem_ready_i  = 1'b1;
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = w;
            step();
            imem_ready_i  = 1'b0;
            imem_rvalid_i = 1'b0;
            check1("seq_valid", InstrValid_o, 1'b1);
            check32("seq_instr", Instr_o, w);
            check32("seq_pc", PC_o, 32'(i * 4));
            check32("seq_pc4", PCPlus4_o, 32'(i * 4 + 4));
            retire_i = 1'b1;
            step();
            retire_i = 1'b0;
        end

        // Directed table: branches, jal, latency, timeout boundary, PC wrap.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            fetch_one(tbl[k].rdy, tbl[k].rsp, tbl[k].word, tbl[k].addr);
            do_retire(tbl[k].ret, tbl[k].src, tbl[k].tgt, tbl[k].word);
        end

        // Randomized program against a PC model.
        pc_m = 32'h0000_0008;
        for (int k = 0; k < 30; k++) begin
            w   = $urandom();
            tmp = $urandom();
            tmp[1:0] = 2'b00;
            src = 1'($urandom_range(0, 1));
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, MAX_WAIT)), w, pc_m);
            do_retire(int'($urandom_range(0, 2)), src, tmp, w);
            pc_m = src ? tmp : pc_m + 32'd4;
        end

        // Timeout: no response for MAX_WAIT cycles.
        wait_req();
        check32("to_addr", imem_addr_o, pc_m);
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        repeat (MAX_WAIT - 1) step();
        check1("to_not_yet", timeout_o, 1'b0);
        step();
        check1("to_set", timeout_o, 1'b1);
        check1("to_err_no_req", imem_req_o, 1'b0);
        retire_i      = 1'b1;
        imem_rvalid_i = 1'b1;
        repeat (3) step();
        retire_i      = 1'b0;
        imem_rvalid_i = 1'b0;
        check1("err_no_valid", InstrValid_o, 1'b0);
        check1("err_no_req", imem_req_o, 1'b0);
        check1("err_timeout_sticky", timeout_o, 1'b1);
        check32("err_pc_held", PC_o, pc_m);
        do_reset();

        // Misaligned branch target.
        fetch_one(0, 0, 32'h0420_006F, 32'h0);
        retire_i   = 1'b1;
        PCSrc_i    = 1'b1;
        PCTarget_i = 32'h0000_0042;
        step();
        retire_i = 1'b0;
        PCSrc_i  = 1'b0;
        check1("mis_set", misalign_o, 1'b1);
        check1("mis_no_valid", InstrValid_o, 1'b0);
        check32("mis_pc_held", PC_o, 32'h0);
        repeat (2) step();
        check1("mis_no_req", imem_req_o, 1'b0);
        do_reset();

        // Reset abandons an in-flight request at PC 0x20.
        fetch_one(0, 0, 32'h0200_006F, 32'h0);
        do_retire(0, 1'b1, 32'h0000_0020, 32'h0200_006F);
        wait_req();
        check32("wait_addr", imem_addr_o, 32'h0000_0020);
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        check1("in_wait", imem_req_o, 1'b0);
        do_reset();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hFEED_FACE;
        step();
        imem_rvalid_i = 1'b0;
        check1("post_rst_req", imem_req_o, 1'b1);
        check32("post_rst_addr", imem_addr_o, 32'h0);
        check1("post_rst_no_valid", InstrValid_o, 1'b0);
        fetch_one(0, 2, 32'h0000_0093, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
